// File: rtl/cache_mem_responder.sv
// cache_mem_responder: memory-side responder for the cache/IO request handshake.
// Stands in for the DDR2 controller behind the data cache. Accepts one word read
// or write at a time, serves it from an internal word array after LATENCY cycles
// and returns a single-cycle registered ready pulse.
//
// Parameters:
//   ADDR_BITS     - word-array index width (depth = 2**ADDR_BITS 32-bit words)
//   LATENCY       - cycles from acceptance to ready pulse, legal range 1..15
// Ports:
//   clk           - system clock
//   rst           - asynchronous active-low reset
//   io_valid_data - request valid
//   io_rw_data    - 1 = write, 0 = read
//   mem_addr      - word address, low ADDR_BITS index the array
//   io_wr_data    - write data
//   io_rd_data    - registered read data, held until the next read response
//   io_ready_data - registered one-cycle completion pulse
//   io_err_data   - out-of-range flag, valid with ready (CACHE_MEM_RESP_ERR_EN only)
//
// Optional feature macro: CACHE_MEM_RESP_ERR_EN
//   Defined: nonzero mem_addr[27:ADDR_BITS] is out of range; writes are dropped,
//   reads return 32'hDEADBEEF and io_err_data is raised with ready.
//   Undefined: upper address bits are ignored, addresses alias modulo the depth.
module cache_mem_responder #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_valid_data,
  input  logic        io_rw_data,
  input  logic [27:0] mem_addr,
  input  logic [31:0] io_wr_data,
  output logic [31:0] io_rd_data,
`ifdef CACHE_MEM_RESP_ERR_EN
  output logic        io_err_data,
`endif
  output logic        io_ready_data
);

  localparam int unsigned Depth   = 2 ** ADDR_BITS;
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);
  localparam logic [31:0] ErrWord = 32'hDEAD_BEEF;

  // Elaboration-time guard on the counter range.
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("cache_mem_responder: LATENCY=%0d outside 1..15", LATENCY);
  end

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                 state_q;
  logic [3:0]             cnt_q;
  logic                   rw_q;
  logic [ADDR_BITS-1:0]   idx_q;
  logic [31:0]            wdata_q;
  logic                   oor_q;
  logic                   ready_q;
  logic [31:0]            rd_data_q;

  logic [31:0]            mem_q [Depth];

  logic                   addr_oor;
  logic                   cur_rw;
  logic [ADDR_BITS-1:0]   cur_idx;
  logic [31:0]            cur_wdata;
  logic                   cur_oor;
  logic                   enter_resp;

`ifdef CACHE_MEM_RESP_ERR_EN
  logic err_q;
  assign addr_oor    = |mem_addr[27:ADDR_BITS];
  assign io_err_data = err_q;
`else
  logic unused_addr_hi;
  assign addr_oor       = 1'b0;
  assign unused_addr_hi = ^mem_addr[27:ADDR_BITS];
`endif

  // In IDLE the live inputs describe the request (needed when LATENCY=1 commits
  // on the acceptance edge); afterwards only the latched copy matters.
  always_comb begin
    cur_rw     = rw_q;
    cur_idx    = idx_q;
    cur_wdata  = wdata_q;
    cur_oor    = oor_q;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        cur_rw     = io_rw_data;
        cur_idx    = mem_addr[ADDR_BITS-1:0];
        cur_wdata  = io_wr_data;
        cur_oor    = addr_oor;
        enter_resp = io_valid_data && (LATENCY == 1);
      end
      StWait:  enter_resp = (cnt_q == 4'd1);
      default: enter_resp = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      rw_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= 32'h0;
      oor_q     <= 1'b0;
      ready_q   <= 1'b0;
      rd_data_q <= 32'h0;
`ifdef CACHE_MEM_RESP_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      ready_q <= enter_resp;
`ifdef CACHE_MEM_RESP_ERR_EN
      err_q   <= enter_resp && cur_oor;
`endif
      if (enter_resp && !cur_rw) begin
        rd_data_q <= cur_oor ? ErrWord : mem_q[cur_idx];
      end
      unique case (state_q)
        StIdle: begin
          if (io_valid_data) begin
            rw_q    <= io_rw_data;
            idx_q   <= mem_addr[ADDR_BITS-1:0];
            wdata_q <= io_wr_data;
            oor_q   <= addr_oor;
            cnt_q   <= CntInit;
            state_q <= (LATENCY == 1) ? StResp : StWait;
          end
        end
        StWait: begin
          if (cnt_q == 4'd1) begin
            cnt_q   <= 4'd0;
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Array is not reset; a reset before the commit edge leaves state_q in IDLE,
  // so an aborted request never reaches this write.
  always_ff @(posedge clk) begin
    if (enter_resp && cur_rw && !cur_oor) begin
      mem_q[cur_idx] <= cur_wdata;
    end
  end

  assign io_rd_data    = rd_data_q;
  assign io_ready_data = ready_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
module tb_cache_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v4 = 1'b0;
  logic        v1 = 1'b0;
  logic        rw = 1'b0;
  logic [27:0] addr = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd4, rd1;
  logic        rdy4, rdy1;
`ifdef CACHE_MEM_RESP_ERR_EN
  logic        err4, err1;
`endif

  int total = 0;
  int bad = 0;
  logic [31:0] last_rd [2];
  logic [31:0] sb_q [$];

  always #5 clk = ~clk;

  cache_mem_responder #(.ADDR_BITS(10), .LATENCY(4)) u_dut4 (
    .clk           (clk),
    .rst           (rst),
    .io_valid_data (v4),
    .io_rw_data    (rw),
    .mem_addr      (addr),
    .io_wr_data    (wd),
    .io_rd_data    (rd4),
`ifdef CACHE_MEM_RESP_ERR_EN
    .io_err_data   (err4),
`endif
    .io_ready_data (rdy4)
  );

  cache_mem_responder #(.ADDR_BITS(10), .LATENCY(1)) u_dut1 (
    .clk           (clk),
    .rst           (rst),
    .io_valid_data (v1),
    .io_rw_data    (rw),
    .mem_addr      (addr),
    .io_wr_data    (wd),
    .io_rd_data    (rd1),
`ifdef CACHE_MEM_RESP_ERR_EN
    .io_err_data   (err1),
`endif
    .io_ready_data (rdy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic get_rdy(input int sel);
    return (sel == 0) ? rdy4 : rdy1;
  endfunction

  function automatic logic [31:0] get_rd(input int sel);
    return (sel == 0) ? rd4 : rd1;
  endfunction

  function automatic logic get_err(input int sel);
`ifdef CACHE_MEM_RESP_ERR_EN
    return (sel == 0) ? err4 : err1;
`else
    return (sel < 0);
`endif
  endfunction

  // Called at a negedge with the selected DUT idle. Scrambles the inputs right
  // after acceptance so only the latched request can produce the result.
  task automatic req(input int sel, input logic r_w, input logic [27:0] a,
                     input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
    int n;
    int lat;
    lat = (sel == 0) ? 4 : 1;
    rw = r_w; addr = a; wd = d;
    if (sel == 0) v4 = 1'b1; else v1 = 1'b1;
    if (!r_w) sb_q.push_back(exp_rd);
    @(negedge clk);
    v4 = 1'b0; v1 = 1'b0;
    wd = ~d; addr = a ^ 28'h3; rw = ~r_w;
    n = 1;
    while (!get_rdy(sel) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
    chk("ready_seen", {31'b0, get_rdy(sel)}, 32'd1);
    if (!r_w) begin
      if (sb_q.size() > 0) last_rd[sel] = sb_q.pop_front();
    end
    chk(r_w ? "rd_hold_on_write" : "rd_data", get_rd(sel), last_rd[sel]);
`ifdef CACHE_MEM_RESP_ERR_EN
    chk("err_in_ready", {31'b0, get_err(sel)}, {31'b0, exp_err});
`else
    if (exp_err && get_err(sel)) chk("err_absent", 32'd1, 32'd0);
`endif
    @(negedge clk);
    chk("ready_pulse_end", {31'b0, get_rdy(sel)}, 32'd0);
    chk("rd_hold_idle", get_rd(sel), last_rd[sel]);
  endtask

  typedef struct {
    logic        rw;
    logic [27:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  initial begin
    vec_t vecs [8];
    vecs[0] = '{1'b1, 28'd5,    32'hCAFE_F00D, 32'h0};
    vecs[1] = '{1'b0, 28'd5,    32'h0,         32'hCAFE_F00D};
    vecs[2] = '{1'b1, 28'd9,    32'h0000_0001, 32'h0};
    vecs[3] = '{1'b1, 28'd1023, 32'hA5A5_A5A5, 32'h0};
    vecs[4] = '{1'b1, 28'd0,    32'h1111_1111, 32'h0};
    vecs[5] = '{1'b0, 28'd1023, 32'h0,         32'hA5A5_A5A5};
    vecs[6] = '{1'b0, 28'd9,    32'h0,         32'h0000_0001};
    vecs[7] = '{1'b0, 28'd0,    32'h0,         32'h1111_1111};
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;

    // Reset held for 3 cycles, then idle with no request.
    repeat (3) @(negedge clk);
    chk("rst_ready4", {31'b0, rdy4}, 32'd0);
    chk("rst_rd4", rd4, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_ready4", {31'b0, rdy4}, 32'd0);
      chk("idle_rd4", rd4, 32'h0);
      chk("idle_ready1", {31'b0, rdy1}, 32'd0);
    end

    // Table-driven traffic on the LATENCY=4 instance.
    for (int i = 0; i < 8; i++) begin
      req(0, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, 1'b0);
    end

    // Reset during WAIT: aborts the write to address 9 and suppresses ready.
    rw = 1'b1; addr = 28'd9; wd = 32'h1234_5678; v4 = 1'b1;
    @(negedge clk);
    v4 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_ready", {31'b0, rdy4}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_ready", {31'b0, rdy4}, 32'd0);
    end
    chk("midrst_rd", rd4, 32'h0);
    req(0, 1'b0, 28'd9, 32'h0, 32'h0000_0001, 1'b0);

    // Out-of-range access at 28'h400.
    req(0, 1'b1, 28'h400, 32'hBBBB_0000, 32'h0, 1'b1);
`ifdef CACHE_MEM_RESP_ERR_EN
    req(0, 1'b0, 28'h400, 32'h0, 32'hDEAD_BEEF, 1'b1);
    req(0, 1'b0, 28'h0, 32'h0, 32'h1111_1111, 1'b0);
`else
    req(0, 1'b0, 28'h400, 32'h0, 32'hBBBB_0000, 1'b0);
    req(0, 1'b0, 28'h0, 32'h0, 32'hBBBB_0000, 1'b0);
`endif

    // LATENCY=1: latched write data survives input changes after acceptance.
    req(1, 1'b1, 28'd3, 32'h55AA_55AA, 32'h0, 1'b0);
    req(1, 1'b0, 28'd3, 32'h0, 32'h55AA_55AA, 1'b0);

    // LATENCY=1 back-to-back with valid held high: one completion every 2 cycles.
    rw = 1'b1; addr = 28'd10; wd = 32'hB000_0000; v1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("b2b_ready_hi", {31'b0, rdy1}, 32'd1);
      if (i >= 3) begin
        last_rd[1] = 32'hB000_0000 + 32'(i - 3);
        chk("b2b_rd", rd1, last_rd[1]);
      end
      if (i < 5) begin
        rw   = (i + 1 < 3);
        addr = 28'd10 + 28'((i + 1) % 3);
        wd   = 32'hB000_0000 + 32'(i + 1);
      end else begin
        v1 = 1'b0;
      end
      @(negedge clk);
      chk("b2b_ready_lo", {31'b0, rdy1}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
